// File: rtl/ram_control_seq_if.sv
// ----------------------------------------------------------------------------
// ram_control_seq_if
//   Bundles the control, ROM and datapath signals of ram_control_seq.
//
//   Control : start, abort, start_addr[7:0], last_addr[7:0]
//   ROM     : en, addr[7:0] (to ROM), data[15:0] (from ROM, one-cycle latency)
//   Datapath: ctrl[15:0], ctrl_valid (to datapath), ctrl_ready (from datapath)
//   Status  : busy, done, step_count[8:0]
//
//   slave  : the sequencer side (ram_control_seq)
//   master : the environment side (controller, ROM and datapath)
// ----------------------------------------------------------------------------
interface ram_control_seq_if;
  logic        start;
  logic        abort;
  logic [7:0]  start_addr;
  logic [7:0]  last_addr;
  logic        en;
  logic [7:0]  addr;
  logic [15:0] data;
  logic [15:0] ctrl;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic        busy;
  logic        done;
  logic [8:0]  step_count;

  modport slave (
    input  start, abort, start_addr, last_addr, data, ctrl_ready,
    output en, addr, ctrl, ctrl_valid, busy, done, step_count
  );

  modport master (
    output start, abort, start_addr, last_addr, data, ctrl_ready,
    input  en, addr, ctrl, ctrl_valid, busy, done, step_count
  );
endinterface

// File: rtl/ram_control_seq.sv
// ----------------------------------------------------------------------------
// ram_control_seq
//   Control-word sequencer. On start it reads a contiguous (mod-256) range of
//   16-bit control words from a one-cycle-latency ROM and streams them to a
//   datapath over a valid/ready handshake at up to one word per cycle.
//
//   Ports
//     clk  : system clock, rising edge only
//     rst  : synchronous active-high reset
//     bus  : ram_control_seq_if.slave (control, ROM, datapath and status)
//
//   States: IDLE -> FETCH (issue first read) -> RUN (present words) -> DONE
//   (one-cycle done pulse) -> IDLE. abort in FETCH/RUN returns to IDLE.
//
//   Configuration
//     RAM_CONTROL_SEQ_SKIP_NOP_EN : when defined, all-zero words read in RUN
//       are dropped internally (never presented, never counted).
// ----------------------------------------------------------------------------
module ram_control_seq (
  input  logic               clk,
  input  logic               rst,
  ram_control_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  fetch_addr_q, fetch_addr_d;
  logic [7:0]  last_q, last_d;
  logic [8:0]  step_count_q, step_count_d;

  logic        at_last;   // word on data is the final one of the range
  logic        is_nop;    // RUN word that is skipped rather than presented
  logic        xfer;      // datapath handshake completes this cycle
  logic        consume;   // current RUN word is retired (handshake or skip)

  logic        en_o;
  logic [7:0]  addr_o;
  logic [15:0] ctrl_o;
  logic        ctrl_valid_o;

  // --------------------------------------------------------------------------
  // Word qualification
  // --------------------------------------------------------------------------
  always_comb begin
    at_last = (fetch_addr_q == last_q);
`ifdef RAM_CONTROL_SEQ_SKIP_NOP_EN
    is_nop  = (state_q == RUN) && (bus.data == 16'h0000);
`else
    is_nop  = 1'b0;
`endif
    xfer    = (state_q == RUN) && !is_nop && bus.ctrl_ready;
    consume = xfer || is_nop;
  end

  // --------------------------------------------------------------------------
  // ROM and datapath drive. The ROM read for word N+1 is issued in the same
  // cycle word N retires, so data only advances when the current word leaves;
  // while stalled en stays low and the ROM holds its output.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would infer a latch.
    en_o         = 1'b0;
    addr_o       = 8'h00;
    ctrl_o       = 16'h0000;
    ctrl_valid_o = 1'b0;
    unique case (state_q)
      FETCH: begin
        en_o   = 1'b1;
        addr_o = fetch_addr_q;
      end
      RUN: begin
        ctrl_o       = bus.data;
        ctrl_valid_o = !is_nop;
        // A skipped word retires unconditionally, so it may prefetch too.
        en_o         = (bus.ctrl_ready || is_nop) && !at_last;
        addr_o       = fetch_addr_q + 8'd1;
      end
      default: ;
    endcase
  end

  assign bus.en         = en_o;
  assign bus.addr       = addr_o;
  assign bus.ctrl       = ctrl_o;
  assign bus.ctrl_valid = ctrl_valid_o;
  assign bus.busy       = (state_q == FETCH) || (state_q == RUN);
  assign bus.done       = (state_q == DONE);
  assign bus.step_count = step_count_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    last_d       = last_q;
    step_count_d = step_count_q;

    unique case (state_q)
      IDLE: begin
        // start wins over a simultaneous abort; abort is not sampled here.
        if (bus.start) begin
          fetch_addr_d = bus.start_addr;
          last_d       = bus.last_addr;
          step_count_d = 9'd0;
          state_d      = FETCH;
        end
      end
      FETCH: begin
        state_d = bus.abort ? IDLE : RUN;
      end
      RUN: begin
        // abort discards any handshake happening in the same cycle.
        if (bus.abort) begin
          state_d = IDLE;
        end else if (consume) begin
          if (xfer) step_count_d = step_count_q + 9'd1;
          if (at_last) state_d      = DONE;
          else         fetch_addr_d = fetch_addr_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      fetch_addr_q <= 8'h00;
      last_q       <= 8'h00;
      step_count_q <= 9'd0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      last_q       <= last_d;
      step_count_q <= step_count_d;
    end
  end

endmodule

// File: tb/tb_ram_control_seq.sv
// ----------------------------------------------------------------------------
// tb_ram_control_seq
//   Directed bench for ram_control_seq with a one-cycle-latency ROM model.
//   Inputs change and outputs are sampled 2 ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_ram_control_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_control_seq_if bus ();

  ram_control_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ROM model: registered read, output held while en is low.
  logic [15:0] rom [256];
  always @(posedge clk) if (bus.en) bus.data <= rom[bus.addr];

  int passed = 0;
  int total  = 0;

  logic [7:0]  got_addr [$];
  logic [15:0] got_word [$];
  bit          saw_done;

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = {8'hA5, 8'(i)};
  endtask

  // Launches a run with ctrl_ready=1 and records every issued ROM address and
  // every transferred word until done or the budget runs out. With
  // poke_start set, start is held high (with other addresses) through the run.
  task automatic run_collect(input logic [7:0] sa, input logic [7:0] la,
                             input int budget, input bit poke_start);
    got_addr.delete();
    got_word.delete();
    saw_done = 1'b0;
    bus.start_addr = sa;
    bus.last_addr  = la;
    bus.ctrl_ready = 1'b1;
    bus.start      = 1'b1;
    cycle();
    bus.start = poke_start;
    if (poke_start) begin
      bus.start_addr = 8'hF0;
      bus.last_addr  = 8'hF1;
    end
    for (int c = 0; c < budget && !saw_done; c++) begin
      if (bus.en) got_addr.push_back(bus.addr);
      if (bus.ctrl_valid && bus.ctrl_ready) got_word.push_back(bus.ctrl);
      if (bus.done) saw_done = 1'b1;
      else          cycle();
    end
    bus.start = 1'b0;
    total++; if (saw_done !== 1'b1) $display("FAIL run_timeout: done got %0b want 1", saw_done); else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.abort = 1'b0; bus.start_addr = 8'h33; bus.last_addr = 8'h44; bus.ctrl_ready = 1'b1;
    cycle();
    cycle();
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", bus.busy); else passed++;
    total++; if (bus.en !== 1'b0 || bus.addr !== 8'h00) $display("FAIL reset_rom: got en=%0b addr=%h want 0/00", bus.en, bus.addr); else passed++;
    total++; if (bus.ctrl_valid !== 1'b0 || bus.ctrl !== 16'h0) $display("FAIL reset_ctrl: got v=%0b ctrl=%h want 0/0000", bus.ctrl_valid, bus.ctrl); else passed++;
    total++; if (bus.done !== 1'b0 || bus.step_count !== 9'd0) $display("FAIL reset_status: got done=%0b step=%0d want 0/0", bus.done, bus.step_count); else passed++;
    rst = 1'b0; bus.start = 1'b0;
    cycle();
  endtask

  task automatic test_basic();
    logic [15:0] exp_w [4];
    exp_w[0] = 16'h0008; exp_w[1] = 16'h0004; exp_w[2] = 16'h0002; exp_w[3] = 16'h0010;
    bus.start_addr = 8'd3; bus.last_addr = 8'd6; bus.ctrl_ready = 1'b1; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1 || bus.en !== 1'b1 || bus.addr !== 8'd3 || bus.ctrl_valid !== 1'b0)
      $display("FAIL basic_fetch: got busy=%0b en=%0b addr=%h v=%0b want 1/1/03/0", bus.busy, bus.en, bus.addr, bus.ctrl_valid); else passed++;
    cycle();
    for (int i = 0; i < 4; i++) begin
      total++; if (bus.ctrl_valid !== 1'b1 || bus.ctrl !== exp_w[i])
        $display("FAIL basic_word%0d: got v=%0b ctrl=%h want 1/%h", i, bus.ctrl_valid, bus.ctrl, exp_w[i]); else passed++;
      total++; if (bus.en !== (i < 3) || bus.addr !== 8'(4 + i) || bus.done !== 1'b0)
        $display("FAIL basic_pref%0d: got en=%0b addr=%h done=%0b want %0b/%h/0", i, bus.en, bus.addr, bus.done, (i < 3), 8'(4 + i)); else passed++;
      cycle();
    end
    total++; if (bus.done !== 1'b1 || bus.ctrl_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL basic_done: got done=%0b v=%0b busy=%0b want 1/0/0", bus.done, bus.ctrl_valid, bus.busy); else passed++;
    total++; if (bus.step_count !== 9'd4) $display("FAIL basic_steps: got %0d want 4", bus.step_count); else passed++;
    cycle();
    total++; if (bus.done !== 1'b0 || bus.step_count !== 9'd4)
      $display("FAIL basic_after: got done=%0b step=%0d want 0/4", bus.done, bus.step_count); else passed++;
  endtask

  task automatic test_stall();
    bus.start_addr = 8'd3; bus.last_addr = 8'd6; bus.ctrl_ready = 1'b1; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    cycle();                          // RUN, 0008 transfers at next edge
    cycle();                          // RUN, 0004 presented
    for (int i = 0; i < 3; i++) begin
      bus.ctrl_ready = 1'b0;
      #1;
      total++; if (bus.ctrl_valid !== 1'b1 || bus.ctrl !== 16'h0004 || bus.en !== 1'b0)
        $display("FAIL stall_%0d: got v=%0b ctrl=%h en=%0b want 1/0004/0", i, bus.ctrl_valid, bus.ctrl, bus.en); else passed++;
      cycle();
    end
    bus.ctrl_ready = 1'b1;
    #1;
    total++; if (bus.ctrl !== 16'h0004 || bus.en !== 1'b1 || bus.addr !== 8'd5)
      $display("FAIL stall_release: got ctrl=%h en=%0b addr=%h want 0004/1/05", bus.ctrl, bus.en, bus.addr); else passed++;
    cycle();
    total++; if (bus.ctrl !== 16'h0002) $display("FAIL stall_next: got %h want 0002", bus.ctrl); else passed++;
    cycle();
    total++; if (bus.ctrl !== 16'h0010) $display("FAIL stall_last: got %h want 0010", bus.ctrl); else passed++;
    cycle();
    total++; if (bus.done !== 1'b1 || bus.step_count !== 9'd4)
      $display("FAIL stall_done: got done=%0b step=%0d want 1/4", bus.done, bus.step_count); else passed++;
    cycle();
  endtask

  task automatic test_wrap();
    logic [7:0]  exp_a [4];
    logic [15:0] exp_w [4];
    exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
    exp_w[0] = 16'h1111; exp_w[1] = 16'h2222; exp_w[2] = 16'h3333; exp_w[3] = 16'h4444;
    for (int i = 0; i < 4; i++) rom[exp_a[i]] = exp_w[i];
    run_collect(8'hFE, 8'h01, 20, 1'b0);
    total++; if (got_addr.size() != 4 || got_word.size() != 4)
      $display("FAIL wrap_len: got addrs=%0d words=%0d want 4/4", got_addr.size(), got_word.size());
    else begin
      passed++;
      for (int i = 0; i < 4; i++) begin
        total++; if (got_addr[i] !== exp_a[i] || got_word[i] !== exp_w[i])
          $display("FAIL wrap_%0d: got addr=%h word=%h want %h/%h", i, got_addr[i], got_word[i], exp_a[i], exp_w[i]); else passed++;
      end
    end
    total++; if (bus.step_count !== 9'd4) $display("FAIL wrap_steps: got %0d want 4", bus.step_count); else passed++;
    cycle();
  endtask

  task automatic test_full_range();
    fill_rom();
    run_collect(8'h05, 8'h04, 300, 1'b0);
    total++; if (got_word.size() != 256 || bus.step_count !== 9'd256)
      $display("FAIL full_len: got words=%0d step=%0d want 256/256", got_word.size(), bus.step_count); else passed++;
    total++; if (got_addr.size() != 256 || got_addr[0] !== 8'h05 || got_addr[255] !== 8'h04 || got_word[255] !== 16'hA504)
      $display("FAIL full_ends: got n=%0d first=%h last=%h want 256/05/04", got_addr.size(), got_addr[0], got_addr[255]); else passed++;
    cycle();
  endtask

  task automatic test_abort();
    bit done_seen = 1'b0;
    bus.start_addr = 8'd3; bus.last_addr = 8'd6; bus.ctrl_ready = 1'b1; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    cycle();                          // RUN cycle 1
    cycle();                          // RUN cycle 2
    bus.abort = 1'b1;
    cycle();
    bus.abort = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.ctrl_valid !== 1'b0 || bus.step_count !== 9'd1)
      $display("FAIL abort_run: got busy=%0b v=%0b step=%0d want 0/0/1", bus.busy, bus.ctrl_valid, bus.step_count); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (bus.done) done_seen = 1'b1;
      cycle();
    end
    total++; if (done_seen !== 1'b0) $display("FAIL abort_done: got %0b want 0", done_seen); else passed++;
    // abort during FETCH, and start+abort together in IDLE
    bus.start = 1'b1; bus.abort = 1'b1;
    cycle();
    bus.start = 1'b0;
    total++; if (bus.busy !== 1'b1 || bus.step_count !== 9'd0 || bus.addr !== 8'd3)
      $display("FAIL abort_startwins: got busy=%0b step=%0d addr=%h want 1/0/03", bus.busy, bus.step_count, bus.addr); else passed++;
    cycle();
    bus.abort = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL abort_fetch: got busy=%0b done=%0b want 0/0", bus.busy, bus.done); else passed++;
    cycle();
  endtask

  task automatic test_nop();
    rom[0] = 16'h0000; rom[1] = 16'h0000; rom[2] = 16'h0000; rom[3] = 16'h0008;
    run_collect(8'h00, 8'h03, 20, 1'b0);
`ifdef RAM_CONTROL_SEQ_SKIP_NOP_EN
    total++; if (got_word.size() != 1 || bus.step_count !== 9'd1)
      $display("FAIL nop_len: got words=%0d step=%0d want 1/1", got_word.size(), bus.step_count);
    else begin
      passed++;
      total++; if (got_word[0] !== 16'h0008) $display("FAIL nop_word: got %h want 0008", got_word[0]); else passed++;
    end
`else
    total++; if (got_word.size() != 4 || bus.step_count !== 9'd4)
      $display("FAIL nop_len: got words=%0d step=%0d want 4/4", got_word.size(), bus.step_count);
    else begin
      passed++;
      total++; if (got_word[0] !== 16'h0 || got_word[2] !== 16'h0 || got_word[3] !== 16'h0008)
        $display("FAIL nop_words: got %h %h %h want 0000 0000 0008", got_word[0], got_word[2], got_word[3]); else passed++;
    end
`endif
    cycle();
  endtask

  task automatic test_back_to_back();
    rom[3] = 16'h0008; rom[4] = 16'h0004; rom[5] = 16'h0002; rom[6] = 16'h0010;
    // start held high throughout the run must not restart or redirect it
    run_collect(8'd3, 8'd6, 20, 1'b1);
    total++; if (got_word.size() != 4 || got_word[1] !== 16'h0004 || got_word[3] !== 16'h0010 || bus.step_count !== 9'd4)
      $display("FAIL b2b_ignore_start: got n=%0d step=%0d want 4/4", got_word.size(), bus.step_count); else passed++;
    cycle();
    // reset mid-run, then a normal run
    bus.start_addr = 8'd3; bus.last_addr = 8'd6; bus.ctrl_ready = 1'b1; bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.en !== 1'b0 || bus.addr !== 8'h0 || bus.ctrl !== 16'h0 ||
                 bus.ctrl_valid !== 1'b0 || bus.done !== 1'b0 || bus.step_count !== 9'd0)
      $display("FAIL midrun_reset: got busy=%0b en=%0b addr=%h ctrl=%h v=%0b done=%0b step=%0d want all 0",
               bus.busy, bus.en, bus.addr, bus.ctrl, bus.ctrl_valid, bus.done, bus.step_count); else passed++;
    run_collect(8'd3, 8'd6, 20, 1'b0);
    total++; if (got_word.size() != 4 || got_word[0] !== 16'h0008 || got_word[2] !== 16'h0002 || bus.step_count !== 9'd4)
      $display("FAIL post_reset_run: got n=%0d step=%0d want 4/4", got_word.size(), bus.step_count); else passed++;
    cycle();
  endtask

  initial begin
    fill_rom();
    rom[3] = 16'h0008; rom[4] = 16'h0004; rom[5] = 16'h0002; rom[6] = 16'h0010;
    bus.data = 16'h0;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_abort();
    test_full_range();
    test_nop();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
